zap_ram_arbiter: RTL and testbench

Arbiter and sequencer for one 1W/1R pipelined simple RAM macro with 2-cycle read latency and same-cycle/next-cycle write forwarding.
- Shares the RAM's single read port between two requesters using round-robin arbitration.
- Owns the write port, and interleaves writes with reads at full rate.
- Tags in-flight reads so each read response is returned to the requester that issued it.
- Clears the whole array to INIT_VALUE after reset and on request.

---
 rtl/zap_ram_arbiter.sv | 84 ++++++++
 tb/tb_zap_ram_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_ram_arbiter.sv
// zap_ram_arbiter: round-robin read arbiter, write sequencer and array initialiser for a 1W/1R RAM with 2-cycle read latency
//   i_clk, i_reset (async, active-high)
//   i_init_req / o_busy           : start an array clear / high while clearing
//   i_rdN_*, o_rdN_*  (N = 0, 1)  : read request, grant and tagged response per requester
//   i_wr_*, o_wr_gnt              : write request and grant
//   o_ram_*, i_ram_rd_data        : RAM macro interface
module zap_ram_arbiter #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 32,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_init_req,
    output logic                     o_busy,
    input  logic                     i_rd0_req,
    input  logic [$clog2(DEPTH)-1:0] i_rd0_addr,
    output logic                     o_rd0_gnt,
    output logic                     o_rd0_valid,
    output logic [WIDTH-1:0]         o_rd0_data,
    input  logic                     i_rd1_req,
    input  logic [$clog2(DEPTH)-1:0] i_rd1_addr,
    output logic                     o_rd1_gnt,
    output logic                     o_rd1_valid,
    output logic [WIDTH-1:0]         o_rd1_data,
    input  logic                     i_wr_req,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic                     o_wr_gnt,
    output logic                     o_ram_clken,
    output logic                     o_ram_wr_en,
    output logic [$clog2(DEPTH)-1:0] o_ram_wr_addr,
    output logic [WIDTH-1:0]         o_ram_wr_data,
    output logic [$clog2(DEPTH)-1:0] o_ram_rd_addr,
    input  logic [WIDTH-1:0]         i_ram_rd_data
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t        state, state_next;
    logic [AW-1:0] cnt;
    logic          rr;
    logic          s1_v, s1_id, s2_v, s2_id;
    logic          run, cnt_last, gnt0, gnt1;
    always_comb begin
        run           = (state == ST_RUN);
        cnt_last      = (cnt == AW'(DEPTH - 1));
        // rr names the requester that wins a tie
        gnt0          = run & i_rd0_req & (~i_rd1_req | ~rr);
        gnt1          = run & i_rd1_req & (~i_rd0_req | rr);
        state_next    = run ? (i_init_req ? ST_INIT : ST_RUN) : (cnt_last ? ST_RUN : ST_INIT);
        o_busy        = ~run;
        o_rd0_gnt     = gnt0;
        o_rd1_gnt     = gnt1;
        o_wr_gnt      = run & i_wr_req;
        o_ram_clken   = 1'b1;
        o_ram_wr_en   = ~run | i_wr_req;
        o_ram_wr_addr = ~run ? cnt : (i_wr_req ? i_wr_addr : '0);
        o_ram_wr_data = ~run ? INIT_VALUE : (i_wr_req ? i_wr_data : '0);
        o_ram_rd_addr = gnt0 ? i_rd0_addr : (gnt1 ? i_rd1_addr : '0);
        o_rd0_valid   = s2_v & ~s2_id;
        o_rd1_valid   = s2_v & s2_id;
        o_rd0_data    = i_ram_rd_data;
        o_rd1_data    = i_ram_rd_data;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_INIT;
            cnt   <= '0;
            rr    <= 1'b0;
            s1_v  <= 1'b0;
            s1_id <= 1'b0;
            s2_v  <= 1'b0;
            s2_id <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= (run | cnt_last) ? '0 : cnt + AW'(1);
            rr    <= gnt0 ? 1'b1 : (gnt1 ? 1'b0 : rr);
            s1_v  <= gnt0 | gnt1;
            s1_id <= gnt1;
            s2_v  <= s1_v;
            s2_id <= s1_id;
        end
    end
endmodule

// File: tb/tb_zap_ram_arbiter.sv
// tb_zap_ram_arbiter: randomized and directed bench with a queue-based reference model for zap_ram_arbiter
module tb_zap_ram_arbiter;
    logic        i_clk, i_reset, i_init_req, o_busy;
    logic        i_rd0_req, o_rd0_gnt, o_rd0_valid;
    logic [4:0]  i_rd0_addr;
    logic [31:0] o_rd0_data;
    logic        i_rd1_req, o_rd1_gnt, o_rd1_valid;
    logic [4:0]  i_rd1_addr;
    logic [31:0] o_rd1_data;
    logic        i_wr_req, o_wr_gnt;
    logic [4:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic        o_ram_clken, o_ram_wr_en;
    logic [4:0]  o_ram_wr_addr, o_ram_rd_addr;
    logic [31:0] o_ram_wr_data, i_ram_rd_data;

    zap_ram_arbiter dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_init_req(i_init_req), .o_busy(o_busy),
        .i_rd0_req(i_rd0_req), .i_rd0_addr(i_rd0_addr), .o_rd0_gnt(o_rd0_gnt),
        .o_rd0_valid(o_rd0_valid), .o_rd0_data(o_rd0_data),
        .i_rd1_req(i_rd1_req), .i_rd1_addr(i_rd1_addr), .o_rd1_gnt(o_rd1_gnt),
        .o_rd1_valid(o_rd1_valid), .o_rd1_data(o_rd1_data),
        .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_gnt(o_wr_gnt),
        .o_ram_clken(o_ram_clken), .o_ram_wr_en(o_ram_wr_en), .o_ram_wr_addr(o_ram_wr_addr),
        .o_ram_wr_data(o_ram_wr_data), .o_ram_rd_addr(o_ram_rd_addr), .i_ram_rd_data(i_ram_rd_data)
    );

    always #5 i_clk = ~i_clk;

    // RAM macro: 2-cycle read latency, writes through cycle t+1 visible to a read addressed at t
    logic [31:0] ram [32];
    logic [4:0]  ra1, ra2;
    always @(posedge i_clk) begin
        if (o_ram_wr_en) ram[o_ram_wr_addr] <= o_ram_wr_data;
        ra1 <= o_ram_rd_addr;
        ra2 <= ra1;
    end
    assign i_ram_rd_data = ram[ra2];

    int n_cmp = 0;
    int n_bad = 0;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", n, act, exp_v);
        end
    endtask

    // Reference model: expected array contents, pending responses, init progress, tie favourite
    typedef struct {
        int         due;
        logic       id;
        logic [4:0] addr;
    } rd_t;
    rd_t         q[$];
    rd_t         pend;
    logic [31:0] mmem [32];
    logic        m_init = 1'b1;
    logic [4:0]  m_iaddr = '0;
    logic        m_fav = 1'b0;
    int          cyc = 0;
    logic        e_run, e_g0, e_g1, e_wen, e_v0, e_v1;
    logic [4:0]  e_waddr, e_raddr;
    logic [31:0] e_wdata, e_d;

    always @(negedge i_clk) begin
        if (i_reset) begin
            m_init  = 1'b1;
            m_iaddr = '0;
            m_fav   = 1'b0;
            q.delete();
        end
        e_run   = !m_init;
        e_g0    = e_run && i_rd0_req && (!i_rd1_req || !m_fav);
        e_g1    = e_run && i_rd1_req && (!i_rd0_req || m_fav);
        e_raddr = e_g0 ? i_rd0_addr : (e_g1 ? i_rd1_addr : 5'd0);
        e_wen   = m_init || i_wr_req;
        e_waddr = m_init ? m_iaddr : (i_wr_req ? i_wr_addr : 5'd0);
        e_wdata = m_init ? 32'd0 : (i_wr_req ? i_wr_data : 32'd0);
        e_v0 = 1'b0;
        e_v1 = 1'b0;
        e_d  = '0;
        foreach (q[i]) if (q[i].due == cyc) begin
            if (q[i].id) e_v1 = 1'b1;
            else e_v0 = 1'b1;
            e_d = mmem[q[i].addr];
        end
        chk("busy", o_busy, m_init);
        chk("rd0_gnt", o_rd0_gnt, e_g0);
        chk("rd1_gnt", o_rd1_gnt, e_g1);
        chk("wr_gnt", o_wr_gnt, e_run && i_wr_req);
        chk("ram_clken", o_ram_clken, 1'b1);
        chk("ram_wr_en", o_ram_wr_en, e_wen);
        chk("ram_wr_addr", o_ram_wr_addr, e_waddr);
        chk("ram_wr_data", o_ram_wr_data, e_wdata);
        chk("ram_rd_addr", o_ram_rd_addr, e_raddr);
        chk("rd0_valid", o_rd0_valid, e_v0);
        chk("rd1_valid", o_rd1_valid, e_v1);
        if (e_v0) chk("rd0_data", o_rd0_data, e_d);
        if (e_v1) chk("rd1_data", o_rd1_data, e_d);
        if (e_wen) mmem[e_waddr] = e_wdata;
        if (!i_reset) begin
            if (e_g0 || e_g1) begin
                pend.due  = cyc + 2;
                pend.id   = e_g1;
                pend.addr = e_raddr;
                q.push_back(pend);
            end
            if (e_g0) m_fav = 1'b1;
            else if (e_g1) m_fav = 1'b0;
            if (m_init) begin
                if (m_iaddr == 5'd31) begin
                    m_init  = 1'b0;
                    m_iaddr = '0;
                end else m_iaddr = m_iaddr + 5'd1;
            end else if (i_init_req) m_init = 1'b1;
        end
        while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
        cyc++;
    end

    task automatic idle();
        i_init_req = 0; i_rd0_req = 0; i_rd1_req = 0; i_wr_req = 0;
        i_rd0_addr = 0; i_rd1_addr = 0; i_wr_addr = 0; i_wr_data = 0;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    int         busy_n, val_n;
    logic [5:0] pat;

    initial begin
        i_clk = 0;
        i_reset = 1;
        idle();
        ra1 = 0;
        ra2 = 0;
        for (int i = 0; i < 32; i++) begin
            ram[i]  = 32'hBAD0_0000 | i;
            mmem[i] = 32'hBAD0_0000 | i;
        end
        step();
        step();
        i_reset = 0;
        busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (k == 0) chk("init_first_addr", o_ram_wr_addr, 32'd0);
            if (o_busy) busy_n++;
            step();
        end
        chk("busy_cycles_after_reset", busy_n, 32);

        i_rd0_req = 1; i_rd0_addr = 5;
        @(negedge i_clk); chk("rd5_gnt0", o_rd0_gnt, 1'b1);
        step(); idle();
        step();
        @(negedge i_clk);
        chk("rd5_valid0", o_rd0_valid, 1'b1);
        chk("rd5_data", o_rd0_data, 32'd0);
        chk("rd5_valid1", o_rd1_valid, 1'b0);
        step();

        i_wr_req = 1; i_wr_addr = 3; i_wr_data = 32'hDEADBEEF;
        step(); idle();
        i_rd1_req = 1; i_rd1_addr = 3;
        step(); idle();
        step();
        @(negedge i_clk);
        chk("wr3_valid1", o_rd1_valid, 1'b1);
        chk("wr3_data", o_rd1_data, 32'hDEADBEEF);
        chk("wr3_valid0", o_rd0_valid, 1'b0);
        step();

        pat = '0;
        i_rd0_req = 1; i_rd0_addr = 3; i_rd1_req = 1; i_rd1_addr = 5;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            pat[k] = o_rd1_gnt;
            step();
        end
        idle();
        chk("alternation", pat, 6'b101010);
        step(); step();

        i_wr_req = 1; i_wr_addr = 7; i_wr_data = 32'h12345678; i_rd0_req = 1; i_rd0_addr = 7;
        step(); idle();
        i_wr_req = 1; i_wr_addr = 7; i_wr_data = 32'hAAAA5555;
        step(); idle();
        @(negedge i_clk);
        chk("fwd_valid0", o_rd0_valid, 1'b1);
        chk("fwd_data", o_rd0_data, 32'hAAAA5555);
        step();

        i_rd0_req = 1; i_rd0_addr = 3;
        step(); idle();
        i_rd1_req = 1; i_rd1_addr = 7; i_init_req = 1;
        @(negedge i_clk); chk("init_cycle_gnt1", o_rd1_gnt, 1'b1);
        step(); idle();
        i_rd0_req = 1; i_rd0_addr = 1; i_init_req = 1;
        busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (k == 0) begin
                chk("inflight_valid0", o_rd0_valid, 1'b1);
                chk("inflight_data0", o_rd0_data, 32'hDEADBEEF);
                chk("init_gnt0_blocked", o_rd0_gnt, 1'b0);
            end
            if (k == 1) begin
                chk("inflight_valid1", o_rd1_valid, 1'b1);
                chk("inflight_data1", o_rd1_data, 32'hAAAA5555);
                i_rd0_req = 0;
                i_init_req = 0;
            end
            if (o_busy) busy_n++;
            step();
        end
        chk("busy_cycles_after_init_req", busy_n, 32);

        i_rd0_req = 1; i_rd0_addr = 1;
        step(); idle();
        i_reset = 1;
        step();
        i_reset = 0;
        val_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            if (k == 0) chk("reset_init_addr", o_ram_wr_addr, 32'd0);
            if (o_rd0_valid || o_rd1_valid) val_n++;
            step();
        end
        chk("dropped_valids", val_n, 0);
        repeat (30) step();

        for (int k = 0; k < 4000; k++) begin
            i_rd0_req  = $urandom_range(0, 1);
            i_rd1_req  = $urandom_range(0, 1);
            i_wr_req   = $urandom_range(0, 1);
            i_rd0_addr = 5'($urandom_range(0, 31));
            i_rd1_addr = 5'($urandom_range(0, 31));
            i_wr_addr  = 5'($urandom_range(0, 31));
            i_wr_data  = $urandom;
            i_init_req = ($urandom_range(0, 99) == 0);
            i_reset    = ($urandom_range(0, 499) == 0);
            step();
            i_reset = 0;
        end
        idle();
        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
